tx_huge_page_notify: RTL and testbench
======================================

Name: tx_huge_page_notify

Overview:
- Host-notification transmitter for the huge-page TX path, on the PCIe TRN transmit interface.
- When the hardware finishes consuming huge page 1 or 2, it emits a one-DW posted Memory Write TLP to a host status address. It then pulses huge_page_to_host_N, which clears the page's to-hw flag in the huge-page address receiver.
- It shares the TRN TX port with other requesters through a req/gnt arbiter.

Parameters:
- STATUS_STRIDE, 8, byte offset between the page 1 and page 2 status words. Must be a multiple of 4.

Ports:
- trn_clk  in  1  TRN clock.
- reset  in  1  asynchronous, active-high reset.
- status_addr  in  64  host byte address of the page 1 status word; bits [1:0] ignored. Sampled at TLP start.
- cfg_completer_id  in  16  requester ID placed in the header.
- huge_page_done_1  in  1  one-cycle pulse: page 1 fully consumed.
- huge_page_done_2  in  1  one-cycle pulse: page 2 fully consumed.
- huge_page_to_host_1  out  1  one-cycle pulse after the page 1 TLP is accepted.
- huge_page_to_host_2  out  1  one-cycle pulse after the page 2 TLP is accepted.
- notify_req  out  1  TX port request to the arbiter.
- notify_gnt  in  1  TX port grant; held high while notify_req is high.
- trn_td  out  64  TLP data.
- trn_trem_n  out  8  remainder: 00 = 2 DW valid, 0F = upper DW only.
- trn_tsof_n  out  1  start of frame, active low.
- trn_teof_n  out  1  end of frame, active low.
- trn_tsrc_rdy_n  out  1  source ready, active low.
- trn_tdst_rdy_n  in  1  destination ready, active low.

Behaviour:
- Reset values:
  - to_host pulses 0; notify_req 0.
  - trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n all 1.
  - trn_td 0; trn_trem_n 0.
  - Pending bits cleared; last_served = page 2, so page 1 wins the first tie.
  - fsm = IDLE.
- Reset mid-TLP aborts the frame immediately with no to_host pulse; pending requests are lost.
- Pending: done_N sets pend_N. pend_N clears on the cycle the final beat of page N's TLP is accepted. A done_N that arrives while page N's TLP is in flight is kept: set wins over clear.
- Selection in IDLE:
  - One bit pending: serve that page.
  - Both pending: serve the page not in last_served.
- Target address: status_addr when page 1 is served; status_addr + STATUS_STRIDE (64-bit add) when page 2 is served. Latched as tgt when IDLE leaves.
- Format: tgt[63:32] == 0 gives a 3DW MWr32 (fmt/type 7'b10_00000); otherwise a 4DW MWr64 (7'b11_00000).
- Header fields: TC 0, TD 0, EP 0, attr 0, length 1, tag 0, last BE 0, first BE F.
- Payload: host little-endian value 1 (page 1) or 2 (page 2), byte-swapped onto the bus, i.e. 32'h0100_0000 or 32'h0200_0000.
- Beat layout, DW0 in bits [63:32]:
  - 3DW beat 1: DW0, DW1.
  - 3DW beat 2: {tgt[31:2], 2'b00}, payload, with trem_n 00.
  - 4DW beat 1: DW0, DW1.
  - 4DW beat 2: tgt[63:32], {tgt[31:2], 2'b00}.
  - 4DW beat 3: payload in [63:32], [31:0] = 0, with trem_n 0F.
- FSM:
  - IDLE: any pend bit set -> latch page/tgt/format, assert notify_req, go to REQ.
  - REQ: notify_gnt = 1 -> go to B1.
  - B1: drive beat 1 with tsof_n = 0 and tsrc_rdy_n = 0. When tdst_rdy_n = 0, go to B2.
  - B2: 3DW -> teof_n = 0. When accepted, 3DW goes to FIN and 4DW goes to B3.
  - B3: teof_n = 0. When accepted, go to FIN.
  - FIN: pulse huge_page_to_host_N for 1 cycle, deassert notify_req, update last_served, go to IDLE.
- A beat with tdst_rdy_n = 1 holds td, trem_n and sof/eof stable.
- tsrc_rdy_n is 0 only in states B1 to B3; there are no idle gaps inside a frame.
- Latency with no back-pressure and an immediate grant: done pulse at cycle t gives IDLE at t+1, REQ at t+2, B1 at t+3, to_host pulse at t+5 (3DW) or t+6 (4DW).
- notify_req falls in the same cycle as the to_host pulse.

Test Plan:
- 3DW, page 1: status_addr = 0x0000_0000_1234_5670, done_1 pulse, gnt tied high.
  - Beat 1 = {32'h4000_0001, cfg_completer_id, 8'h00, 8'h0F}.
  - Beat 2 = {32'h1234_5670, 32'h0100_0000} with trem_n 00.
  - huge_page_to_host_1 pulses once, at t+5.
- 4DW, page 2: status_addr = 0x0000_0001_0000_0008, STATUS_STRIDE = 8, done_2 pulse.
  - DW0 = 32'h6000_0001.
  - Beat 2 = {32'h0000_0001, 32'h0000_0010}.
  - Beat 3 = {32'h0200_0000, 0} with trem_n 0F.
  - huge_page_to_host_2 pulses once.
- Simultaneous done_1 and done_2 out of reset: page 1 TLP is sent, then page 2. Exactly one to_host pulse per page, in that order.
- Back-pressure: tdst_rdy_n high for 3 cycles at each beat. Beats are held stable, there are no duplicate beats, and the to_host pulse is delayed by 3 cycles per stalled beat.
- Grant withheld for 10 cycles: notify_req stays high and tsrc_rdy_n stays 1 until notify_gnt rises. done_1 arriving during the B2 of a page 1 TLP produces a second page 1 TLP.
- Reset asserted during B2: outputs reach reset values asynchronously and there is no to_host pulse. After release, a new done_1 pulse produces a complete, well-formed TLP.

Source files
------------

// File: rtl/tx_huge_page_notify.sv
// Huge-page host notifier: emits a one-DW posted MWr to the page's status word on the
// TRN TX port, then pulses huge_page_to_host_N so the address receiver can recycle the page.
module tx_huge_page_notify #(
    parameter int STATUS_STRIDE = 8
) (
    input  logic        trn_clk,
    input  logic        reset,
    input  logic [63:0] status_addr,
    input  logic [15:0] cfg_completer_id,
    input  logic        huge_page_done_1,
    input  logic        huge_page_done_2,
    output logic        huge_page_to_host_1,
    output logic        huge_page_to_host_2,
    output logic        notify_req,
    input  logic        notify_gnt,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_B1,
        ST_B2,
        ST_B3,
        ST_FIN
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  pend_reg, pend_next;      // bit 0 = page 1, bit 1 = page 2
    logic        last_served_reg;          // 0 = page 1, 1 = page 2
    logic        page_reg;                 // page of the TLP in flight
    logic [63:0] tgt_reg;
    logic        is_4dw_reg;

    logic        sel_page;
    logic [63:0] sel_tgt;
    logic        latch;
    logic        final_ack;
    logic [1:0]  pend_clr;
    logic [31:0] dw0, dw1, payload;

    // Round-robin tie break: with both pages pending, serve the one not served last.
    always_comb begin
        sel_page = ~last_served_reg;
        if (pend_reg == 2'b01) begin
            sel_page = 1'b0;
        end else if (pend_reg == 2'b10) begin
            sel_page = 1'b1;
        end
    end

    // Word-aligned target; the stride is a multiple of 4 so masking after the add is exact.
    assign sel_tgt = (sel_page ? (status_addr + 64'(STATUS_STRIDE)) : status_addr) & ~64'h3;

    assign final_ack = (((state_reg == ST_B2) && !is_4dw_reg) || (state_reg == ST_B3))
                       && !trn_tdst_rdy_n;
    assign pend_clr  = final_ack ? (page_reg ? 2'b10 : 2'b01) : 2'b00;
    // A done arriving on the clearing cycle must survive, so the set term is OR'd last.
    assign pend_next = (pend_reg & ~pend_clr) | {huge_page_done_2, huge_page_done_1};

    assign dw0     = {1'b0, (is_4dw_reg ? 2'b11 : 2'b10), 5'b00000, 1'b0, 3'b000, 4'b0000,
                      1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
    assign dw1     = {cfg_completer_id, 8'h00, 4'h0, 4'hF};
    assign payload = page_reg ? 32'h0200_0000 : 32'h0100_0000;

    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pend_reg        <= 2'b00;
            last_served_reg <= 1'b1;
            page_reg        <= 1'b0;
            tgt_reg         <= 64'd0;
            is_4dw_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            if (latch) begin
                page_reg   <= sel_page;
                tgt_reg    <= sel_tgt;
                is_4dw_reg <= (sel_tgt[63:32] != 32'd0);
            end
            if (state_reg == ST_FIN) begin
                last_served_reg <= page_reg;
            end
        end
    end

    always_comb begin
        state_next          = state_reg;
        latch               = 1'b0;
        notify_req          = 1'b0;
        huge_page_to_host_1 = 1'b0;
        huge_page_to_host_2 = 1'b0;
        trn_td              = 64'd0;
        trn_trem_n          = 8'h00;
        trn_tsof_n          = 1'b1;
        trn_teof_n          = 1'b1;
        trn_tsrc_rdy_n      = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (|pend_reg) begin
                    latch      = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                notify_req = 1'b1;
                if (notify_gnt) begin
                    state_next = ST_B1;
                end
            end
            ST_B1: begin
                notify_req     = 1'b1;
                trn_tsrc_rdy_n = 1'b0;
                trn_tsof_n     = 1'b0;
                trn_td         = {dw0, dw1};
                if (!trn_tdst_rdy_n) begin
                    state_next = ST_B2;
                end
            end
            ST_B2: begin
                notify_req     = 1'b1;
                trn_tsrc_rdy_n = 1'b0;
                trn_teof_n     = is_4dw_reg;
                trn_td         = is_4dw_reg ? {tgt_reg[63:32], tgt_reg[31:0]}
                                            : {tgt_reg[31:0], payload};
                if (!trn_tdst_rdy_n) begin
                    state_next = is_4dw_reg ? ST_B3 : ST_FIN;
                end
            end
            ST_B3: begin
                notify_req     = 1'b1;
                trn_tsrc_rdy_n = 1'b0;
                trn_teof_n     = 1'b0;
                trn_trem_n     = 8'h0F;
                trn_td         = {payload, 32'd0};
                if (!trn_tdst_rdy_n) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                huge_page_to_host_1 = ~page_reg;
                huge_page_to_host_2 = page_reg;
                state_next          = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_huge_page_notify.sv
// Bench for tx_huge_page_notify: directed scenarios plus random done/back-pressure/grant
// traffic, checked every cycle against a transaction-level model of the notifier.
module tb_tx_huge_page_notify;

    localparam int STRIDE = 8;

    logic        trn_clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] status_addr = 64'd0;
    logic [15:0] cfg_completer_id = 16'hABCD;
    logic        done_1 = 1'b0, done_2 = 1'b0;
    logic        h1, h2, notify_req;
    logic        notify_gnt = 1'b0;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n = 1'b0;

    tx_huge_page_notify #(.STATUS_STRIDE(STRIDE)) dut (
        .trn_clk            (trn_clk),
        .reset              (reset),
        .status_addr        (status_addr),
        .cfg_completer_id   (cfg_completer_id),
        .huge_page_done_1   (done_1),
        .huge_page_done_2   (done_2),
        .huge_page_to_host_1(h1),
        .huge_page_to_host_2(h2),
        .notify_req         (notify_req),
        .notify_gnt         (notify_gnt),
        .trn_td             (trn_td),
        .trn_trem_n         (trn_trem_n),
        .trn_tsof_n         (trn_tsof_n),
        .trn_teof_n         (trn_teof_n),
        .trn_tsrc_rdy_n     (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n     (trn_tdst_rdy_n)
    );

    always #5 trn_clk = ~trn_clk;

    int cyc = 0;
    always @(posedge trn_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [63:0] td;
        logic [7:0]  trem;
        logic        sof;
        logic        eof;
    } beat_t;

    beat_t        exp_q[$];
    logic [71:0]  beat_log[$];
    int           pulse_log[$];
    bit           m_pend1, m_pend2, m_busy, m_wait, m_frame;
    int           m_last = 2;
    int           m_page = 0;
    int           m_pulse = 0;

    function automatic void build_tlp(input int page, input logic [63:0] addr);
        logic [63:0] tgt;
        logic [31:0] dw0, dw1, pv, pay;
        bit          is64;
        beat_t       b;
        tgt  = ((page == 1) ? addr : addr + 64'(STRIDE)) & ~64'h3;
        is64 = (tgt[63:32] != 0);
        dw0  = {1'b0, 1'b1, is64, 5'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 10'd1};
        dw1  = {cfg_completer_id, 8'h00, 4'h0, 4'hF};
        pv   = 32'(page);
        pay  = {pv[7:0], pv[15:8], pv[23:16], pv[31:24]};
        b = '{td: {dw0, dw1}, trem: 8'h00, sof: 1'b0, eof: 1'b1};
        exp_q.push_back(b);
        if (!is64) begin
            b = '{td: {tgt[31:0], pay}, trem: 8'h00, sof: 1'b1, eof: 1'b0};
            exp_q.push_back(b);
        end else begin
            b = '{td: tgt, trem: 8'h00, sof: 1'b1, eof: 1'b1};
            exp_q.push_back(b);
            b = '{td: {pay, 32'd0}, trem: 8'h0F, sof: 1'b1, eof: 1'b0};
            exp_q.push_back(b);
        end
    endfunction

    always @(negedge trn_clk) begin : compare
        int    nxt_pulse;
        bit    clr1, clr2, was_busy;
        beat_t hd;
        if (reset) begin
            check("reset_outputs",
                  {h2, h1, notify_req, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_td},
                  {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 64'd0});
            m_pend1 = 0; m_pend2 = 0; m_busy = 0; m_wait = 0; m_frame = 0;
            m_last = 2; m_pulse = 0;
            exp_q.delete();
        end else begin
            nxt_pulse = 0; clr1 = 0; clr2 = 0;
            was_busy = m_busy;
            check("to_host", {h2, h1}, {m_pulse == 2, m_pulse == 1});
            check("notify_req", notify_req, m_busy && (m_pulse == 0));
            if (m_frame && exp_q.size() > 0) begin
                hd = exp_q[0];
                check("beat", {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n},
                      {hd.td, hd.trem, hd.sof, hd.eof, 1'b0});
            end else begin
                check("idle_framing", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 3'b111);
            end
            if (h1) pulse_log.push_back(1);
            if (h2) pulse_log.push_back(2);
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) beat_log.push_back({trn_td, trn_trem_n});
            if (m_frame && !trn_tdst_rdy_n && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_frame   = 0;
                    nxt_pulse = m_page;
                    m_last    = m_page;
                    if (m_page == 1) clr1 = 1; else clr2 = 1;
                end
            end
            if (m_pulse != 0) m_busy = 0;
            if (m_wait && notify_gnt) begin
                m_wait  = 0;
                m_frame = 1;
            end
            if (!was_busy && (m_pend1 || m_pend2)) begin
                if (m_pend1 && m_pend2) m_page = (m_last == 1) ? 2 : 1;
                else m_page = m_pend1 ? 1 : 2;
                build_tlp(m_page, status_addr);
                m_busy = 1;
                m_wait = 1;
            end
            m_pend1 = (m_pend1 && !clr1) || done_1;
            m_pend2 = (m_pend2 && !clr2) || done_2;
            m_pulse = nxt_pulse;
        end
    end

    // ---------------- arbiter and sink ----------------
    int bp_mode = 0;      // 0: always ready, 1: random, 2: stall 3 cycles per beat
    bit rnd_gnt = 0;
    int gnt_fixed = 0;
    int gnt_delay = 0;
    int gcnt = 0;
    int stall = 0;

    always begin
        @(posedge trn_clk);
        #1;
        if (!notify_req) begin
            notify_gnt = 1'b0;
            gcnt = 0;
            gnt_delay = rnd_gnt ? int'($urandom_range(0, 3)) : gnt_fixed;
        end else if (gcnt >= gnt_delay) begin
            notify_gnt = 1'b1;
        end else begin
            gcnt++;
        end
        case (bp_mode)
            0: trn_tdst_rdy_n = 1'b0;
            1: trn_tdst_rdy_n = ($urandom_range(0, 2) == 0);
            default: begin
                if (!trn_tsrc_rdy_n && stall < 3) begin
                    trn_tdst_rdy_n = 1'b1;
                    stall++;
                end else begin
                    trn_tdst_rdy_n = 1'b0;
                    stall = 0;
                end
            end
        endcase
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic pulse_done(input bit d1, input bit d2, output int t0);
        tick();
        done_1 = d1;
        done_2 = d2;
        t0 = cyc;
        tick();
        done_1 = 1'b0;
        done_2 = 1'b0;
    endtask

    task automatic wait_pulse(input int page, input int t0, input int lat, input string name);
        bit found = 0;
        int at = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge trn_clk);
            if ((page == 1 && h1) || (page == 2 && h2)) begin
                found = 1;
                at = cyc;
            end
        end
        if (!found) check({name, "_timeout"}, 0, 1);
        else check(name, at - t0, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int p01;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // 3DW, page 1
        status_addr = 64'h0000_0000_1234_5670;
        beat_log.delete(); pulse_log.delete();
        pulse_done(1, 0, t0);
        wait_pulse(1, t0, 5, "lat_3dw_p1");
        repeat (5) tick();
        check("p1_nbeats", beat_log.size(), 2);
        check("p1_beat1", beat_log[0], {64'h4000_0001_ABCD_000F, 8'h00});
        check("p1_beat2", beat_log[1], {64'h1234_5670_0100_0000, 8'h00});
        check("p1_npulse", pulse_log.size(), 1);

        // 4DW, page 2
        status_addr = 64'h0000_0001_0000_0008;
        beat_log.delete(); pulse_log.delete();
        pulse_done(0, 1, t0);
        wait_pulse(2, t0, 6, "lat_4dw_p2");
        repeat (5) tick();
        check("p2_nbeats", beat_log.size(), 3);
        check("p2_dw0", beat_log[0][71:40], 32'h6000_0001);
        check("p2_beat2", beat_log[1][71:8], 64'h0000_0001_0000_0010);
        check("p2_beat3", beat_log[2], {64'h0200_0000_0000_0000, 8'h0F});
        check("p2_pulse", {pulse_log.size(), pulse_log[0]}, {32'd1, 32'd2});

        // simultaneous done out of reset
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        status_addr = 64'h0000_0000_0000_1000;
        pulse_log.delete();
        pulse_done(1, 1, t0);
        wait_pulse(1, t0, 5, "sim_p1");
        wait_pulse(2, t0, 10, "sim_p2");
        repeat (5) tick();
        p01 = pulse_log[0] * 10 + pulse_log[1];
        check("sim_order", {pulse_log.size(), p01}, {32'd2, 32'd12});

        // back-pressure: 3 stall cycles per beat
        bp_mode = 2;
        beat_log.delete();
        pulse_done(1, 0, t0);
        wait_pulse(1, t0, 11, "lat_bp");
        repeat (3) tick();
        check("bp_nbeats", beat_log.size(), 2);
        bp_mode = 0;

        // grant withheld 10 cycles; done_1 during B2 gives a second TLP
        gnt_fixed = 10;
        repeat (2) tick();
        pulse_log.delete();
        pulse_done(1, 0, t0);
        while (cyc < t0 + 14) tick();
        done_1 = 1'b1;
        tick();
        done_1 = 1'b0;
        wait_pulse(1, t0, 15, "lat_gnt");
        wait_pulse(1, t0, 30, "lat_second");
        repeat (3) tick();
        check("gnt_npulse", pulse_log.size(), 2);
        gnt_fixed = 0;

        // reset during B2
        repeat (2) tick();
        pulse_log.delete();
        pulse_done(1, 0, t0);
        while (cyc < t0 + 4) tick();
        reset = 1'b1;
        #1;
        check("async_reset",
              {h1, notify_req, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_td},
              {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 64'd0});
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("abort_no_pulse", pulse_log.size(), 0);
        beat_log.delete();
        pulse_done(1, 0, t0);
        wait_pulse(1, t0, 5, "lat_after_reset");
        repeat (3) tick();
        check("rst_beat1", beat_log[0], {64'h4000_0001_ABCD_000F, 8'h00});
        check("rst_beat2", beat_log[1], {64'h0000_1000_0100_0000, 8'h00});

        // random traffic
        bp_mode = 1;
        rnd_gnt = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            done_1 = ($urandom_range(0, 9) == 0);
            done_2 = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                status_addr = {(($urandom_range(0, 1) == 0) ? 32'd0 : $urandom()), $urandom()};
            end
        end
        done_1 = 1'b0;
        done_2 = 1'b0;
        repeat (300) tick();
        check("drain_idle", {m_busy, m_pend1, m_pend2, notify_req}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
